// File: rtl/hb_pkg.sv
// Shared constants and helpers for the heartbeat 7-segment animation engine.
// Segment codes are logical active-high, packed {a,b,c,d,e,f,g} in bits [6:0].
package hb_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_LEFT  = 7'b0000110;  // e,f
  localparam logic [6:0] SEG_RIGHT = 7'b0110000;  // b,c

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  // Counter width for a given modulus, never below one bit.
  function automatic int cnt_width(input int modulus);
    return (modulus <= 1) ? 1 : $clog2(modulus);
  endfunction

  // Map a logical on-set to the physical pin level.
  function automatic logic [6:0] apply_polarity(input logic [6:0] s, input logic active_low);
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/hb_pattern_gen.sv
// Combinational heartbeat pattern: logical segments for one (frame, digit) pair.
// Frame 0 shows the inner pair as LEFT/RIGHT; later frames push the bars outward, swapped.
module hb_pattern_gen
  import hb_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [cnt_width(NUM_DIGITS/2+1)-1:0] frame,
  input  logic [cnt_width(NUM_DIGITS)-1:0]     digit,
  output logic [6:0]                           seg
);

  localparam int H = NUM_DIGITS / 2;

  always_comb begin
    int f;
    int d;
    f   = int'(frame);
    d   = int'(digit);
    seg = SEG_BLANK;
    if (f == 0) begin
      if (d == H - 1)  seg = SEG_LEFT;
      else if (d == H) seg = SEG_RIGHT;
    end else begin
      if (d == H - f)          seg = SEG_RIGHT;
      else if (d == H - 1 + f) seg = SEG_LEFT;
    end
  end

endmodule

// File: rtl/heartbeat_display.sv
// Heartbeat animation engine for a multiplexed 7-segment bank: step prescaler,
// frame FSM (wrap or ping-pong), digit scanner and registered segment/enable outputs.
module heartbeat_display
  import hb_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 25_000_000,
  parameter int SCAN_DIV   = 50_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic                                 mode,
  output logic [6:0]                           seg,
  output logic [NUM_DIGITS-1:0]                an,
  output logic [cnt_width(NUM_DIGITS/2+1)-1:0] frame,
  output logic                                 step
);

  localparam int   F   = NUM_DIGITS / 2 + 1;
  localparam int   FW  = cnt_width(F);
  localparam int   PW  = cnt_width(TICK_DIV);
  localparam int   SW  = cnt_width(SCAN_DIV);
  localparam int   DW  = cnt_width(NUM_DIGITS);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PW-1:0] psc;
  logic          tick;
  logic [SW-1:0] scnt;
  logic          scan_wrap;
  logic [DW-1:0] digit;
  logic [FW-1:0] frame_next;
  dir_t          dir, dir_next;
  logic [6:0]    pat;

  // Step prescaler freezes with en, so a paused step resumes exactly where it stopped.
  assign tick = en && (psc == PW'(TICK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  psc <= '0;
    else if (en) psc <= tick ? '0 : psc + 1'b1;
  end

  assign scan_wrap = (scnt == SW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt  <= '0;
      digit <= '0;
    end else begin
      scnt <= scan_wrap ? '0 : scnt + 1'b1;
      if (scan_wrap) digit <= (digit == DW'(NUM_DIGITS - 1)) ? '0 : digit + 1'b1;
    end
  end

  // Wrap mode keeps the direction parked at up, so entering ping-pong always climbs first.
  // NOTE: defaults first so no path through the block leaves a variable unassigned (no latch).
  always_comb begin
    frame_next = frame;
    dir_next   = dir;
    if (!mode) dir_next = DIR_UP;
    if (tick) begin
      if (!mode) begin
        frame_next = (frame == FW'(F - 1)) ? '0 : frame + 1'b1;
      end else if (dir == DIR_UP) begin
        if (frame == FW'(F - 1)) begin
          frame_next = frame - 1'b1;
          dir_next   = DIR_DOWN;
        end else begin
          frame_next = frame + 1'b1;
        end
      end else begin
        if (frame == '0) begin
          frame_next = frame + 1'b1;
          dir_next   = DIR_UP;
        end else begin
          frame_next = frame - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame <= '0;
      dir   <= DIR_UP;
    end else begin
      frame <= frame_next;
      dir   <= dir_next;
    end
  end

  hb_pattern_gen #(.NUM_DIGITS(NUM_DIGITS)) u_pattern (
    .frame (frame),
    .digit (digit),
    .seg   (pat)
  );

  // NOTE: output pins get an explicit reset so the display is dark, not random, while held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg  <= apply_polarity(SEG_BLANK, POL);
      an   <= {NUM_DIGITS{POL}};
      step <= 1'b0;
    end else begin
      seg  <= apply_polarity(pat, POL);
      an   <= (NUM_DIGITS'(1) << digit) ^ {NUM_DIGITS{POL}};
      step <= tick;
    end
  end

endmodule

// File: tb/tb_heartbeat_display.sv
// Self-checking bench: step scoreboard for the 4-digit build plus cycle-exact
// scan/pattern checks, and a free-running 8-digit active-high build alongside.
module tb_heartbeat_display;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       mode  = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] frame;
  logic       step;

  logic       en2   = 1'b1;
  logic       mode2 = 1'b0;
  logic [6:0] seg2;
  logic [7:0] an2;
  logic [2:0] frame2;
  logic       step2;

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;
  int model_frame = 0;
  int prev_model  = 0;
  int last_step   = 0;
  int hit_r = 0;
  int hit_l = 0;

  typedef struct {
    int frame;
    int gap;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  heartbeat_display #(.NUM_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .seg(seg), .an(an), .frame(frame), .step(step)
  );

  heartbeat_display #(.NUM_DIGITS(8), .TICK_DIV(4), .SCAN_DIV(1), .ACTIVE_LOW(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2),
    .seg(seg2), .an(an2), .frame(frame2), .step(step2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic push(input int f, input int g);
    exp_t e;
    e.frame = f;
    e.gap   = g;
    q.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (q.size() != 0 && n < 200);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d expected steps still pending, required 0", q.size());
      q.delete();
    end
  endtask

  // Hand table for the 4-digit active-low build: frame0 _LR_, frame1 _RL_, frame2 R__L.
  function automatic logic [6:0] exp_seg4(input int f, input int d);
    logic [6:0] b, l, r;
    b = 7'b1111111;
    l = 7'b1111001;
    r = 7'b1001111;
    case (f)
      0:       return (d == 1) ? l : (d == 2) ? r : b;
      1:       return (d == 1) ? r : (d == 2) ? l : b;
      2:       return (d == 0) ? r : (d == 3) ? l : b;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  // Monitor: ncyc = clock edges since reset release; outputs lag (frame, digit) by one edge.
  always @(negedge clk) begin
    int d, d8, f8, f8_prev;
    logic [3:0] exp_an;
    logic [7:0] exp_an2;
    logic [6:0] exp_s8;
    logic       chk8;
    exp_t       e;
    if (!rst_n) begin
      model_frame = 0;
      prev_model  = 0;
      last_step   = 0;
    end else if (ncyc >= 1) begin
      d      = ((ncyc - 1) / 2) % 4;
      exp_an = ~(4'b0001 << d);
      check("an_scan", 32'(an), 32'(exp_an));
      check("seg_pattern", 32'(seg), 32'(exp_seg4(prev_model, d)));
      if (step) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_step: step=1 at cycle %0d, required no step", ncyc);
        end else begin
          e = q.pop_front();
          check("step_frame", 32'(frame), e.frame);
          check("step_gap", ncyc - last_step, e.gap);
          model_frame = e.frame;
        end
        last_step = ncyc;
      end
      check("frame_hold", 32'(frame), model_frame);
      prev_model = model_frame;

      d8      = (ncyc - 1) % 8;
      f8      = (ncyc / 4) % 5;
      f8_prev = ((ncyc - 1) / 4) % 5;
      exp_an2 = 8'b0000_0001 << d8;
      check("an8_onehot", 32'(an2), 32'(exp_an2));
      check("frame8", 32'(frame2), f8);
      check("step8", 32'(step2), 32'((ncyc % 4) == 0));
      chk8   = 1'b1;
      exp_s8 = 7'b0000000;
      if (f8_prev == 4) begin
        if (d8 == 0) begin exp_s8 = 7'b0110000; hit_r++; end
        if (d8 == 7) begin exp_s8 = 7'b0000110; hit_l++; end
      end else if (f8_prev == 0) begin
        if (d8 == 3) exp_s8 = 7'b0000110;
        if (d8 == 4) exp_s8 = 7'b0110000;
      end else begin
        chk8 = 1'b0;
      end
      if (chk8) check("seg8_pattern", 32'(seg2), 32'(exp_s8));
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_seg", 32'(seg), 32'h7f);
      check("rst_an", 32'(an), 32'hf);
      check("rst_frame", 32'(frame), 0);
      check("rst_step", 32'(step), 0);
      check("rst_seg8", 32'(seg2), 0);
      check("rst_an8", 32'(an2), 0);
    end

    // Wrap mode: 0,1,2,0,1, one step every 4 cycles.
    @(posedge clk); #2;
    en = 1'b1;
    push(1, 4); push(2, 4); push(0, 4); push(1, 4);
    rst_n = 1'b1;
    wait_drain(); #2;

    // Ping-pong from frame 1: 2,1,0,1,2 with no repeat at either end.
    mode = 1'b1;
    push(2, 4); push(1, 4); push(0, 4); push(1, 4); push(2, 4);
    wait_drain(); #2;

    // Freeze one cycle into the prescale for 10 cycles: next step 4+10 cycles later.
    push(1, 14);
    en = 1'b0;
    repeat (10) @(posedge clk);
    #2 en = 1'b1;
    wait_drain(); #2;

    push(0, 4); push(1, 4); push(2, 4);
    wait_drain(); #2;

    // Asynchronous reset at frame 2, checked before any clock edge.
    rst_n = 1'b0;
    #1;
    check("async_seg", 32'(seg), 32'h7f);
    check("async_an", 32'(an), 32'hf);
    check("async_frame", 32'(frame), 0);
    check("async_step", 32'(step), 0);
    check("async_seg8", 32'(seg2), 0);
    check("async_an8", 32'(an2), 0);
    check("async_frame8", 32'(frame2), 0);
    mode = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #2;
    push(1, 4); push(2, 4); push(0, 4); push(1, 4);
    rst_n = 1'b1;
    wait_drain();
    repeat (3) @(posedge clk);

    check("seen_frame4_right_digit0", 32'(hit_r != 0), 1);
    check("seen_frame4_left_digit7", 32'(hit_l != 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/heartbeat_display.md
Name: heartbeat_display

Overview:
- Parametrised heartbeat animation engine for a multiplexed common-anode 7-segment bank.
- Generates the step timebase and advances an animation frame index. Scans the digits in time, one at a time, and drives segment plus digit-enable lines directly.
- Generalises the fixed 4-digit, 12-entry heartbeat decoder to NUM_DIGITS digits, with selectable segment polarity.
- Adds enable/freeze control and a ping-pong mode.

Parameters:
- NUM_DIGITS, 4: number of digits; even, 2..16. H = NUM_DIGITS/2; frame count F = H+1.
- TICK_DIV, 25_000_000: clk cycles per animation step; >= 2.
- SCAN_DIV, 50_000: clk cycles per digit scan slot; >= 1.
- ACTIVE_LOW, 1: 1 means segment and digit-enable outputs are active-low (1 = off); 0 inverts both.

Ports:
- clk, input, 1: system clock; single clock domain.
- rst_n, input, 1: reset, asynchronous, active-low.
- en, input, 1: 1 = animation advances; 0 = frame held. Scanning continues while en=0.
- mode, input, 1: 0 = wrap (frame F-1 -> 0); 1 = ping-pong (0..F-1..0).
- seg, output, 7: segments {a,b,c,d,e,f,g} in bits [6:0]. Registered.
- an, output, NUM_DIGITS: digit enables, one active at a time; an[0] = leftmost digit. Registered.
- frame, output, clog2(F): current frame index. Registered.
- step, output, 1: one-cycle pulse on the cycle the frame register updates.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - prescaler = 0, scan counter = 0, digit index = 0, frame = 0, direction = up, step = 0.
  - seg = all-off and an = all-off (all 1s when ACTIVE_LOW=1).
  - Outputs return to normal on the first clk edge after deassertion; reset mid-animation always restarts at frame 0.
- Step prescaler:
  - Counts 0..TICK_DIV-1 while en=1, then wraps and raises tick.
  - Holds its value while en=0; no tick is lost or duplicated across en toggles.
- Frame update on tick:
  - mode=0: frame = (frame == F-1) ? 0 : frame+1.
  - mode=1: up direction, increment until frame F-1, then flip to down. Down direction, decrement until frame 0, then flip to up. No frame is repeated at the turnaround.
  - step pulses on the same edge the frame updates.
- Mode change mid-run: takes effect at the next tick.
  - Switching to mode=0 clears the direction to up.
  - Switching to mode=1 starts with direction up.
- Scan:
  - Scan counter runs 0..SCAN_DIV-1 regardless of en.
  - On wrap, digit index = (index == NUM_DIGITS-1) ? 0 : index+1.
- Output latency:
  - seg and an are registered from the current (frame, digit index): 1-cycle latency.
  - an has exactly one active bit at every cycle after the first post-reset edge; no cycle has two digits on.
- Pattern, in logical on-set terms; polarity is applied at the output register:
  - BLANK = none; LEFT = {e,f}; RIGHT = {b,c}.
  - Frame 0: digit H-1 = LEFT, digit H = RIGHT, all others BLANK.
  - Frame f >= 1: digit H-f = RIGHT, digit H-1+f = LEFT, all others BLANK.
  - Check for NUM_DIGITS=4: frame0 = _ L R _, frame1 = _ R L _, frame2 = R _ _ L.
- Simultaneous events:
  - If tick and scan wrap fall on the same cycle, the next registered seg uses the new frame and the new digit together.
- Arithmetic:
  - Counters are sized by clog2 of their modulus; compare against modulus-1 with no overflow reliance.
  - Widths are at least 1 when a modulus is 1.

Decomposition:
- Shared package hb_pkg holds:
  - segment code constants SEG_BLANK, SEG_LEFT, SEG_RIGHT (logical active-high, abcdefg);
  - polarity helper function;
  - clog2-based width helper.
- One combinational sub-module, hb_pattern_gen: inputs (frame, digit, NUM_DIGITS), output 7-bit logical segments.
- Prescalers, frame FSM, scanner and output registers live in heartbeat_display.

Test Plan (NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=2, ACTIVE_LOW=1 unless noted):
- Reset: hold rst_n=0 for 3 cycles, then release mid-cycle. Required: seg=7'b1111111, an=4'b1111, frame=0 during reset; from the first post-reset edge exactly one an bit is 0.
- Wrap mode, en=1, mode=0: step every 4 cycles; frame sequence 0,1,2,0,1. While frame=2 and an=4'b1110 (digit 0), seg=7'b1001111.
- Ping-pong mode, mode=1: frame sequence 0,1,2,1,0,1,2 with no repeated frame at either end.
- Freeze: deassert en for 10 cycles mid-prescale. Required: frame and step frozen, an keeps rotating 1110->1101->1011->0111 every 2 cycles; the next step occurs exactly the remaining prescale count after en=1.
- Async reset mid-run: pull rst_n low at frame 2 between clock edges. Required: outputs go all-off immediately with no clock edge; frame returns to 0.
- Generic build, NUM_DIGITS=8, ACTIVE_LOW=0: 5 frames; frame 4 shows RIGHT on digit 0 (seg=7'b0110000) and LEFT on digit 7 (seg=7'b0000110); an is one-hot active-high.
